// File: rtl/feeder_pkg.sv
// feeder_pkg: shared state encoding and helpers for systolic_feeder.
package feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_W,
    STREAM,
    WAIT,
    WRITE,
    DONE
  } feeder_state_e;

  // Slack beyond N+M+K before the stream phase gives up on sa_done.
  localparam int WD_MARGIN = 8;

  function automatic int row_sel(input int t, input int rows);
    return (t < rows) ? t : rows - 1;
  endfunction

endpackage

// File: rtl/feeder_addr_gen.sv
// feeder_addr_gen: row-major address walker producing a (row, col)
// index pair and a flag on the final element of the block.
module feeder_addr_gen #(
  parameter int AW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [AW-1:0] base_i,
  input  logic [CW-1:0] row_len_i,
  input  logic [CW-1:0] count_i,
  output logic [AW-1:0] addr_o,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);

  logic [CW-1:0] idx_q;
  logic [CW-1:0] row_q;
  logic [CW-1:0] col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (en_i) begin
      idx_q <= idx_q + CW'(1);
      if (col_q == row_len_i - CW'(1)) begin
        col_q <= '0;
        row_q <= row_q + CW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Wraps modulo 2^AW by construction.
  assign addr_o = base_i + AW'(idx_q);
  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (idx_q == count_i - CW'(1));

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads X/W from memory, streams rows into the array and
// writes Y back. Define FEEDER_RELU_EN to clamp negative results to zero.
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int M          = 25,
  parameter int N          = 36,
  parameter int K          = 7,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h1000,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 'h3000
) (
  input  logic                         clk,
  input  logic                         rst_systolic,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic                         mem_wr_en,
  output logic [ADDR_WIDTH-1:0]        mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  output logic                         sa_rst_n,
  output logic [DATA_WIDTH*M-1:0]      sa_x,
  output logic [DATA_WIDTH*K-1:0]      sa_w,
  input  logic [DATA_WIDTH*M*K-1:0]    sa_y,
  input  logic                         sa_done
);

  localparam int DW   = DATA_WIDTH;
  localparam int AW   = ADDR_WIDTH;
  localparam int NM   = N * M;
  localparam int NK   = N * K;
  localparam int MK   = M * K;
  localparam int CMAX = (NM > NK) ? ((NM > MK) ? NM : MK)
                                  : ((NK > MK) ? NK : MK);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WD   = N + M + K + WD_MARGIN;
  localparam int SW   = $clog2(WD + 1);

  if (M == 0 || N == 0 || K == 0) begin : g_bad_size
    $error("systolic_feeder: M, N and K must all be non-zero");
  end

  feeder_state_e state_q, state_d;
  logic          drain_q, drain_d;
  logic          cap_vld_q;
  logic [CW-1:0] cap_row_q, cap_col_q;
  logic [SW-1:0] t_q;
  logic [DW*MK-1:0] ybuf_q;
  logic [DW-1:0] xbuf_q [N][M];
  logic [DW-1:0] wbuf_q [N][K];

  logic          ld_on, is_w, issue;
  logic [AW-1:0] ld_addr, wr_addr;
  logic [CW-1:0] ld_row, ld_col, wr_row, wr_col;
  logic          ld_last, wr_last;
  logic [DW-1:0] y_word, y_out;
  logic          x_on, w_on;
  int            wrow;

  assign ld_on = (state_q == LOAD_X) || (state_q == LOAD_W);
  assign is_w  = (state_q == LOAD_W);
  assign issue = ld_on && !drain_q;

  feeder_addr_gen #(.AW(AW), .CW(CW)) u_ld (
    .clk       (clk),
    .rst_n     (rst_systolic),
    .clr_i     (!ld_on || drain_q),
    .en_i      (issue),
    .base_i    (is_w ? WEIGHT_BASE : IM2COL_BASE),
    .row_len_i (is_w ? CW'(K) : CW'(M)),
    .count_i   (is_w ? CW'(NK) : CW'(NM)),
    .addr_o    (ld_addr),
    .row_o     (ld_row),
    .col_o     (ld_col),
    .last_o    (ld_last)
  );

  feeder_addr_gen #(.AW(AW), .CW(CW)) u_wr (
    .clk       (clk),
    .rst_n     (rst_systolic),
    .clr_i     (state_q != WRITE),
    .en_i      (state_q == WRITE),
    .base_i    (OUTPUT_BASE),
    .row_len_i (CW'(K)),
    .count_i   (CW'(MK)),
    .addr_o    (wr_addr),
    .row_o     (wr_row),
    .col_o     (wr_col),
    .last_o    (wr_last)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:   if (start) state_d = LOAD_X;
      LOAD_X, LOAD_W: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = is_w ? STREAM : LOAD_W;
        end else if (ld_last) begin
          drain_d = 1'b1;
        end
      end
      STREAM: begin
        if (sa_done)                  state_d = WAIT;
        else if (t_q == SW'(WD - 1))  state_d = WRITE;
      end
      WAIT:   state_d = WRITE;
      WRITE:  if (wr_last) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_systolic) begin
    if (!rst_systolic) begin
      state_q   <= IDLE;
      drain_q   <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_row_q <= '0;
      cap_col_q <= '0;
      t_q       <= '0;
      ybuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cap_vld_q <= issue;
      cap_row_q <= ld_row;
      cap_col_q <= ld_col;
      if (state_q == LOAD_W)      t_q <= '0;
      else if (state_q == STREAM) t_q <= t_q + SW'(1);
      // A run that never sees sa_done writes zeros, not stale results.
      if (state_q == IDLE && start) ybuf_q <= '0;
      else if (state_q == WAIT)     ybuf_q <= sa_y;
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++)
        if (cap_vld_q && !is_w && cap_row_q == CW'(n) && cap_col_q == CW'(m))
          xbuf_q[n][m] <= mem_rd_data;
      for (int k = 0; k < K; k++)
        if (cap_vld_q && is_w && cap_row_q == CW'(n) && cap_col_q == CW'(k))
          wbuf_q[n][k] <= mem_rd_data;
    end
  end

  always_comb begin
    wrow = row_sel(int'(t_q), N);
    x_on = (state_q == STREAM) && (int'(t_q) < N);
    w_on = state_q inside {STREAM, WAIT, WRITE};
    sa_x = '0;
    sa_w = '0;
    for (int n = 0; n < N; n++) begin
      if (x_on && int'(t_q) == n)
        for (int m = 0; m < M; m++) sa_x[m*DW +: DW] = xbuf_q[n][m];
      if (w_on && wrow == n)
        for (int k = 0; k < K; k++) sa_w[k*DW +: DW] = wbuf_q[n][k];
    end
  end

  always_comb begin
    y_word = '0;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++)
        if (wr_row == CW'(m) && wr_col == CW'(k))
          y_word = ybuf_q[(m*K+k)*DW +: DW];
  end

`ifdef FEEDER_RELU_EN
  assign y_out = y_word[DW-1] ? '0 : y_word;
`else
  assign y_out = y_word;
`endif

  assign busy        = state_q inside {LOAD_X, LOAD_W, STREAM, WAIT, WRITE};
  assign done        = (state_q == DONE);
  assign sa_rst_n    = state_q inside {STREAM, WAIT, WRITE};
  assign mem_rd_addr = issue ? ld_addr : '0;
  assign mem_wr_en   = (state_q == WRITE);
  assign mem_wr_addr = mem_wr_en ? wr_addr : '0;
  assign mem_wr_data = mem_wr_en ? y_out : '0;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: random and directed runs of systolic_feeder against
// a matrix-product reference, with memory and array models.
module tb_systolic_feeder;

  localparam int M  = 2;
  localparam int N  = 3;
  localparam int K  = 2;
  localparam int DW = 32;
  localparam int NM = N * M;
  localparam int NK = N * K;
  localparam int MK = M * K;
  localparam logic [31:0] IB = 32'hFFFF_FFFE;
  localparam logic [31:0] WB = 32'h0000_1000;
  localparam logic [31:0] OB = 32'h0000_3000;

  logic              clk = 1'b0;
  logic              rst_systolic = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [31:0]       mem_rd_addr, mem_rd_data;
  logic              mem_wr_en;
  logic [31:0]       mem_wr_addr, mem_wr_data;
  logic              sa_rst_n;
  logic [DW*M-1:0]   sa_x;
  logic [DW*K-1:0]   sa_w;
  logic [DW*MK-1:0]  sa_y;
  logic              sa_done;

  systolic_feeder #(
    .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(32),
    .IM2COL_BASE(IB), .WEIGHT_BASE(WB), .OUTPUT_BASE(OB)
  ) dut (
    .clk(clk), .rst_systolic(rst_systolic), .start(start),
    .busy(busy), .done(done),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .sa_rst_n(sa_rst_n), .sa_x(sa_x), .sa_w(sa_w),
    .sa_y(sa_y), .sa_done(sa_done)
  );

  always #5 clk = ~clk;

  logic [31:0] rmem [65536];
  logic [31:0] xv [N][M];
  logic [31:0] wv [N][K];
  logic [31:0] wmem [MK];
  int          wr_cnt = 0, bad_wr = 0, done_cnt = 0;
  logic        wclr = 1'b0;
  logic [31:0] acc [M][K];
  int          acnt = 0;
  int          adly = 0;
  bit          ahang = 1'b0;

  int          n_pass = 0, n_total = 0;
  int          lat_g, busy_bad, strm;
  logic [31:0] rdq [$];

  always @(posedge clk) mem_rd_data <= rmem[mem_rd_addr[15:0]];

  always @(posedge clk) begin
    if (wclr) begin
      for (int i = 0; i < MK; i++) wmem[i] <= 32'hDEAD_BEEF;
      wr_cnt <= 0; bad_wr <= 0; done_cnt <= 0;
    end else begin
      if (mem_wr_en) begin
        wr_cnt <= wr_cnt + 1;
        if (mem_wr_addr - OB < 32'(MK))
          wmem[int'(mem_wr_addr - OB)] <= mem_wr_data;
        else
          bad_wr <= bad_wr + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // Array model: accumulates outer products of each presented row pair.
  always @(posedge clk) begin
    if (!sa_rst_n) begin
      acnt <= 0;
      for (int m = 0; m < M; m++)
        for (int k = 0; k < K; k++) acc[m][k] <= '0;
    end else begin
      acnt <= acnt + 1;
      for (int m = 0; m < M; m++)
        for (int k = 0; k < K; k++)
          acc[m][k] <= acc[m][k] + sa_x[m*DW +: DW] * sa_w[k*DW +: DW];
    end
  end

  always_comb begin
    sa_done = sa_rst_n && !ahang && (acnt >= N + adly);
    sa_y = '0;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) sa_y[(m*K+k)*DW +: DW] = acc[m][k];
  end

  function automatic logic [31:0] exp_y(int m, int k);
    logic [31:0] s = '0;
    for (int n = 0; n < N; n++) s = s + xv[n][m] * wv[n][k];
`ifdef FEEDER_RELU_EN
    if (s[31]) s = '0;
`endif
    return s;
  endfunction

  function automatic int exp_lat(int s);
    return NM + 1 + NK + 1 + s + 1 + MK + 1;
  endfunction

  task automatic load_mem();
    logic [31:0] a;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        a = IB + 32'(n*M + m);
        rmem[a[15:0]] = xv[n][m];
      end
      for (int k = 0; k < K; k++) begin
        a = WB + 32'(n*K + k);
        rmem[a[15:0]] = wv[n][k];
      end
    end
  endtask

  task automatic clear_out();
    @(negedge clk); wclr = 1'b1;
    @(negedge clk); wclr = 1'b0;
  endtask

  task automatic run_feeder(input int dly, input bit hang,
                            input int restart_at, input bit sdone);
    int cyc;
    bit seen;
    adly = dly; ahang = hang;
    rdq.delete(); busy_bad = 0; strm = 0;
    clear_out();
    start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        start = sdone;
      end else begin
        start = (cyc == restart_at);
        if (busy !== 1'b1) busy_bad++;
        if (sa_rst_n === 1'b0) rdq.push_back(mem_rd_addr);
        else if (mem_wr_en === 1'b0) strm++;
      end
    end
    @(posedge clk); @(negedge clk); start = 1'b0;
    lat_g = seen ? cyc : -1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    n_total++; if (mem_wr_en !== 1'b0) $display("FAIL rst_wr_en: got %b want 0", mem_wr_en); else n_pass++;
    n_total++; if (mem_rd_addr !== 32'h0) $display("FAIL rst_rd_addr: got %h want 0", mem_rd_addr); else n_pass++;
    n_total++; if (mem_wr_addr !== 32'h0) $display("FAIL rst_wr_addr: got %h want 0", mem_wr_addr); else n_pass++;
    n_total++; if (mem_wr_data !== 32'h0) $display("FAIL rst_wr_data: got %h want 0", mem_wr_data); else n_pass++;
    n_total++; if (sa_rst_n !== 1'b0) $display("FAIL rst_sa_rst_n: got %b want 0", sa_rst_n); else n_pass++;
    n_total++; if (sa_x !== '0) $display("FAIL rst_sa_x: got %h want 0", sa_x); else n_pass++;
    n_total++; if (sa_w !== '0) $display("FAIL rst_sa_w: got %h want 0", sa_w); else n_pass++;
    rst_systolic = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] e [$];
    int bad;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) xv[n][m] = 32'(m*N + n + 1);
      for (int k = 0; k < K; k++) wv[n][k] = 32'(n*K + k + 1);
    end
    load_mem();
    run_feeder(2, 1'b0, -1, 1'b0);
    n_total++; if (lat_g != exp_lat(N + 3)) $display("FAIL dir_latency: got %0d want %0d", lat_g, exp_lat(N + 3)); else n_pass++;
    n_total++; if (busy_bad != 0) $display("FAIL dir_busy: got %0d low cycles want 0", busy_bad); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL dir_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (wr_cnt != MK || bad_wr != 0) $display("FAIL dir_writes: got %0d/%0d want %0d/0", wr_cnt, bad_wr, MK); else n_pass++;
    for (int i = 0; i < NM; i++) e.push_back(IB + 32'(i));
    e.push_back(32'h0);
    for (int i = 0; i < NK; i++) e.push_back(WB + 32'(i));
    e.push_back(32'h0);
    bad = (rdq.size() != e.size()) ? 1 : 0;
    if (bad == 0)
      for (int i = 0; i < e.size(); i++) if (rdq[i] !== e[i]) bad++;
    n_total++;
    if (bad != 0) $display("FAIL dir_rd_addr_seq: got %0d addrs (%0d wrong) want %0d", rdq.size(), bad, e.size());
    else n_pass++;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < K; k++) begin
        n_total++;
        if (wmem[m*K+k] !== exp_y(m, k))
          $display("FAIL dir_y[%0d][%0d]: got %h want %h", m, k, wmem[m*K+k], exp_y(m, k));
        else n_pass++;
      end
  endtask

  task automatic test_busy_start();
    run_feeder(1, 1'b0, NM + 3, 1'b1);
    n_total++; if (done_cnt != 1) $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (wr_cnt != MK) $display("FAIL busy_wr_cnt: got %0d want %0d", wr_cnt, MK); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL done_start_ignored: got busy %b want 0", busy); else n_pass++;
    n_total++; if (lat_g != exp_lat(N + 2)) $display("FAIL busy_latency: got %0d want %0d", lat_g, exp_lat(N + 2)); else n_pass++;
    for (int i = 0; i < MK; i++) begin
      n_total++;
      if (wmem[i] !== exp_y(i / K, i % K))
        $display("FAIL busy_y[%0d]: got %h want %h", i, wmem[i], exp_y(i / K, i % K));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc = 0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) xv[n][m] = $urandom_range(0, 255);
      for (int k = 0; k < K; k++) wv[n][k] = $urandom_range(0, 255);
    end
    load_mem();
    adly = 1; ahang = 1'b0;
    clear_out();
    start = 1'b1;
    while (wr_cnt != 2 && cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk); start = 1'b0;
    end
    n_total++;
    if (wr_cnt != 2) $display("FAIL abort_reach_write: got %0d writes want 2", wr_cnt);
    else n_pass++;
    #2 rst_systolic = 1'b0;
    #1;
    n_total++;
    if ({busy, done, mem_wr_en, sa_rst_n} !== 4'b0 || mem_rd_addr !== 32'h0 ||
        mem_wr_addr !== 32'h0 || mem_wr_data !== 32'h0 || sa_x !== '0 || sa_w !== '0)
      $display("FAIL abort_outputs: got ctl %b wa %h wd %h want all 0",
               {busy, done, mem_wr_en, sa_rst_n}, mem_wr_addr, mem_wr_data);
    else n_pass++;
    @(negedge clk); rst_systolic = 1'b1;
    @(negedge clk);
    run_feeder(0, 1'b0, -1, 1'b0);
    n_total++; if (lat_g != exp_lat(N + 1)) $display("FAIL abort_rerun_latency: got %0d want %0d", lat_g, exp_lat(N + 1)); else n_pass++;
    for (int i = 0; i < MK; i++) begin
      n_total++;
      if (wmem[i] !== exp_y(i / K, i % K))
        $display("FAIL abort_rerun_y[%0d]: got %h want %h", i, wmem[i], exp_y(i / K, i % K));
      else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    run_feeder(0, 1'b1, -1, 1'b0);
    n_total++; if (strm != N + M + K + 8) $display("FAIL wd_stream_cycles: got %0d want %0d", strm, N + M + K + 8); else n_pass++;
    n_total++; if (lat_g != exp_lat(N + M + K + 8) - 1) $display("FAIL wd_latency: got %0d want %0d", lat_g, exp_lat(N + M + K + 8) - 1); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL wd_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    for (int i = 0; i < MK; i++) begin
      n_total++;
      if (wmem[i] !== 32'h0) $display("FAIL wd_zero[%0d]: got %h want 0", i, wmem[i]);
      else n_pass++;
    end
    ahang = 1'b0;
  endtask

  task automatic test_relu();
    logic [31:0] y00;
    for (int n = 0; n < N; n++)
      for (int m = 0; m < M; m++) xv[n][m] = (n == m) ? 32'd1 : 32'd0;
    wv[0][0] = -32'sd5; wv[0][1] = 32'd3;
    wv[1][0] = 32'd0;   wv[1][1] = -32'sd1;
    wv[2][0] = 32'd7;   wv[2][1] = 32'd7;
`ifdef FEEDER_RELU_EN
    y00 = 32'h0;
`else
    y00 = 32'hFFFF_FFFB;
`endif
    load_mem();
    run_feeder(0, 1'b0, -1, 1'b0);
    n_total++; if (wmem[0] !== y00) $display("FAIL relu_y00: got %h want %h", wmem[0], y00); else n_pass++;
    for (int i = 0; i < MK; i++) begin
      n_total++;
      if (wmem[i] !== exp_y(i / K, i % K))
        $display("FAIL relu_y[%0d]: got %h want %h", i, wmem[i], exp_y(i / K, i % K));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int d;
    for (int it = 0; it < 4; it++) begin
      for (int n = 0; n < N; n++) begin
        for (int m = 0; m < M; m++) xv[n][m] = $urandom;
        for (int k = 0; k < K; k++) wv[n][k] = $urandom;
      end
      d = $urandom_range(0, 5);
      load_mem();
      run_feeder(d, 1'b0, -1, 1'b0);
      n_total++;
      if (lat_g != exp_lat(N + d + 1))
        $display("FAIL rand%0d_latency: got %0d want %0d", it, lat_g, exp_lat(N + d + 1));
      else n_pass++;
      for (int i = 0; i < MK; i++) begin
        n_total++;
        if (wmem[i] !== exp_y(i / K, i % K))
          $display("FAIL rand%0d_y[%0d]: got %h want %h", it, i, wmem[i], exp_y(i / K, i % K));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_start();
    test_reset_mid_write();
    test_watchdog();
    test_relu();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
